// File: rtl/iter_sched_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | iter_sched_pkg : state encoding and counter-width helper for          |
// |                  the shared iterative datapath scheduler              |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package iter_sched_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    CAPT = 3'd3
  } state_t;

  // Wide enough to hold ITER-1 with a spare bit for the zero test.
  function automatic int cnt_w(input int iter);
    return $clog2(iter) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iter_sched_rr_arb2.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rr_arb2 : two-way round-robin arbiter, one-hot winner (combinational) |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/iter_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | iter_sched : shares one iterative divide/root datapath between two    |
// |              requesters with round-robin arbitration                  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module iter_sched
  import iter_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] opa0,
  input  logic [WIDTH-1:0] opb0,
  input  logic [WIDTH-1:0] opa1,
  input  logic [WIDTH-1:0] opb1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic [WIDTH-1:0] dp_a,
  output logic [WIDTH-1:0] dp_b,
  output logic             dp_start,
  input  logic [WIDTH-1:0] dp_result
);

  localparam int               CNT_W      = cnt_w(ITER);
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(ITER - 1);

  state_t           r_state,  w_state_next;
  logic [CNT_W-1:0] r_cnt,    w_cnt_next;
  logic             r_owner,  w_owner_next;
  logic             r_last,   w_last_next;
  logic [WIDTH-1:0] r_dp_a,   w_dp_a_next;
  logic [WIDTH-1:0] r_dp_b,   w_dp_b_next;
  logic [WIDTH-1:0] r_result, w_result_next;
  logic [1:0]       w_win;
  logic [1:0]       w_owner_oh;
  logic             w_owner_req;

  rr_arb2 u_arb (
    .req  (req),
    .last (r_last),
    .win  (w_win)
  );

  assign w_owner_oh  = r_owner ? 2'b10 : 2'b01;
  assign w_owner_req = req[r_owner];

  assign dp_a   = r_dp_a;
  assign dp_b   = r_dp_b;
  assign result = r_result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_dp_a   <= '0;
      r_dp_b   <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_owner  <= w_owner_next;
      r_last   <= w_last_next;
      r_dp_a   <= w_dp_a_next;
      r_dp_b   <= w_dp_b_next;
      r_result <= w_result_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_owner_next  = r_owner;
    w_last_next   = r_last;
    w_dp_a_next   = r_dp_a;
    w_dp_b_next   = r_dp_b;
    w_result_next = r_result;
    gnt           = 2'b00;
    done          = 2'b00;
    dp_start      = 1'b0;
    busy          = (r_state != IDLE);

    case (r_state)
      IDLE: begin
        if (w_win != 2'b00) begin
          w_owner_next = w_win[1];
          w_last_next  = w_win[1];
          w_dp_a_next  = w_win[1] ? opa1 : opa0;
          w_dp_b_next  = w_win[1] ? opb1 : opb0;
          w_state_next = LOAD;
        end
      end
      LOAD: begin
        gnt      = w_owner_oh;
        dp_start = 1'b1;
        if (!w_owner_req) begin
          w_state_next = IDLE;
        end else begin
          w_cnt_next   = C_CNT_LOAD;
          w_state_next = RUN;
        end
      end
      RUN: begin
        gnt = w_owner_oh;
        // Abort wins over completion so a dropped request never yields done.
        if (!w_owner_req) begin
          w_state_next = IDLE;
        end else if (r_cnt == '0) begin
          w_state_next = CAPT;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      CAPT: begin
        gnt           = w_owner_oh;
        done          = w_owner_oh;
        w_result_next = dp_result;
        w_state_next  = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_iter_sched.sv
`default_nettype none
// Directed bench for iter_sched: default ITER=WIDTH=8 instance plus an ITER=1 instance.
module tb_iter_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [7:0] opa0, opb0, opa1, opb1, dp_result;
  logic [1:0] gnt, done;
  logic [7:0] result, dp_a, dp_b;
  logic       busy, dp_start;

  logic [1:0] req_b;
  logic [7:0] opa0_b, opb0_b, opa1_b, opb1_b, dp_result_b;
  logic [1:0] gnt_b, done_b;
  logic [7:0] result_b, dp_a_b, dp_b_b;
  logic       busy_b, dp_start_b;

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  iter_sched #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .req(req),
    .opa0(opa0), .opb0(opb0), .opa1(opa1), .opb1(opb1),
    .gnt(gnt), .done(done), .result(result), .busy(busy),
    .dp_a(dp_a), .dp_b(dp_b), .dp_start(dp_start), .dp_result(dp_result)
  );

  iter_sched #(.WIDTH(8), .ITER(1)) dut1 (
    .clk(clk), .reset(reset), .req(req_b),
    .opa0(opa0_b), .opb0(opb0_b), .opa1(opa1_b), .opb1(opb1_b),
    .gnt(gnt_b), .done(done_b), .result(result_b), .busy(busy_b),
    .dp_a(dp_a_b), .dp_b(dp_b_b), .dp_start(dp_start_b), .dp_result(dp_result_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Walks one full ITER=8 operation from the IDLE cycle that sees the request
  // up to and including the CAPT cycle.
  task automatic op(input string tag, input logic [1:0] eg, input logic [7:0] ea, input logic [7:0] eb);
    tick;
    chk({tag, "_load_gnt"}, 32'(gnt), 32'(eg));
    chk({tag, "_load_start"}, 32'(dp_start), 32'd1);
    chk({tag, "_load_dpa"}, 32'(dp_a), 32'(ea));
    chk({tag, "_load_dpb"}, 32'(dp_b), 32'(eb));
    chk({tag, "_load_busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick;
      chk({tag, "_run_gnt"}, 32'(gnt), 32'(eg));
      chk({tag, "_run_start"}, 32'(dp_start), 32'd0);
      chk({tag, "_run_done"}, 32'(done), 32'd0);
    end
    tick;
    chk({tag, "_capt_done"}, 32'(done), 32'(eg));
    chk({tag, "_capt_gnt"}, 32'(gnt), 32'(eg));
  endtask

  initial begin
    reset = 1'b1;
    req = 2'b00; opa0 = '0; opb0 = '0; opa1 = '0; opb1 = '0; dp_result = '0;
    req_b = 2'b00; opa0_b = '0; opb0_b = '0; opa1_b = '0; opb1_b = '0; dp_result_b = '0;
    tick;
    tick;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(dp_start), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_dpa", 32'(dp_a), 32'd0);
    reset = 1'b0;

    // Single request from requester 0: 100/7 -> 14
    req = 2'b01; opa0 = 8'd100; opb0 = 8'd7; dp_result = 8'd14;
    tick;
    chk("t1_load_gnt", 32'(gnt), 32'h1);
    chk("t1_load_start", 32'(dp_start), 32'd1);
    opa0 = 8'd55; opb0 = 8'd5;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("t1_run_start", 32'(dp_start), 32'd0);
      chk("t1_run_done", 32'(done), 32'd0);
      chk("t1_run_dpa", 32'(dp_a), 32'd100);
    end
    tick;
    chk("t1_capt_done", 32'(done), 32'h1);
    req = 2'b00;
    tick;
    chk("t1_idle_result", 32'(result), 32'd14);
    chk("t1_idle_gnt", 32'(gnt), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_done", 32'(done), 32'd0);

    // Tie at reset: requester 0 first, then requester 1 after req0 drops
    reset = 1'b1;
    req = 2'b11; opa0 = 8'd20; opb0 = 8'd4; opa1 = 8'd81; opb1 = 8'd9; dp_result = 8'd5;
    tick;
    chk("t2_rst_result", 32'(result), 32'd0);
    reset = 1'b0;
    op("t2a", 2'b01, 8'd20, 8'd4);
    req = 2'b10;
    tick;
    chk("t2a_result", 32'(result), 32'd5);
    chk("t2a_idle_gnt", 32'(gnt), 32'd0);
    dp_result = 8'd9;
    op("t2b", 2'b10, 8'd81, 8'd9);
    tick;
    chk("t2b_result", 32'(result), 32'd9);

    // Continuous tie: grants alternate 01, 10, 01
    req = 2'b11; opa0 = 8'd30; opb0 = 8'd3; opa1 = 8'd64; opb1 = 8'd8; dp_result = 8'd10;
    op("t3a", 2'b01, 8'd30, 8'd3);
    tick;
    chk("t3a_result", 32'(result), 32'd10);
    dp_result = 8'd8;
    op("t3b", 2'b10, 8'd64, 8'd8);
    tick;
    chk("t3b_result", 32'(result), 32'd8);
    opa0 = 8'd49; opb0 = 8'd7; dp_result = 8'd7;
    op("t3c", 2'b01, 8'd49, 8'd7);
    tick;
    chk("t3c_result", 32'(result), 32'd7);

    // Abort: requester 0 drops during RUN cycle 3
    req = 2'b01; opa0 = 8'd11; opb0 = 8'd2; dp_result = 8'd99;
    tick;
    chk("t4_load_gnt", 32'(gnt), 32'h1);
    tick; tick; tick;
    chk("t4_run3_gnt", 32'(gnt), 32'h1);
    req = 2'b00;
    tick;
    chk("t4_abort_busy", 32'(busy), 32'd0);
    chk("t4_abort_gnt", 32'(gnt), 32'd0);
    chk("t4_abort_done", 32'(done), 32'd0);
    chk("t4_abort_result", 32'(result), 32'd7);
    // Aborted owner stays as last, so requester 1 wins the next tie
    req = 2'b11; opa1 = 8'd90; opb1 = 8'd3;
    tick;
    chk("t4_rr_gnt", 32'(gnt), 32'h2);
    chk("t4_rr_dpa", 32'(dp_a), 32'd90);

    // Asynchronous reset mid-RUN
    tick; tick; tick;
    chk("t5_run_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rst_gnt", 32'(gnt), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    chk("t5_rst_start", 32'(dp_start), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_result", 32'(result), 32'd0);
    req = 2'b00;
    tick;
    reset = 1'b0;

    // ITER=1 instance, requester 1
    req_b = 2'b10; opa1_b = 8'h3C; opb1_b = 8'h02; dp_result_b = 8'h1E;
    tick;
    chk("t6_load_start", 32'(dp_start_b), 32'd1);
    chk("t6_load_gnt", 32'(gnt_b), 32'h2);
    chk("t6_load_dpa", 32'(dp_a_b), 32'h3C);
    tick;
    chk("t6_run_start", 32'(dp_start_b), 32'd0);
    chk("t6_run_done", 32'(done_b), 32'd0);
    tick;
    chk("t6_capt_done", 32'(done_b), 32'h2);
    req_b = 2'b00;
    tick;
    chk("t6_result", 32'(result_b), 32'h1E);
    chk("t6_idle_busy", 32'(busy_b), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
`default_nettype wire
